// File: rtl/inst_encoder.sv
// Sequential MIPS32 encoder: abstract op requests -> 32-bit instruction words with byte addresses.
// Latency: a request accepted on edge N is presented on out_inst/out_addr from edge N+1.
// Backpressure: req_ready drops while the output word is stalled, during an LI second word, or on restart.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_sa,
  input  logic [31:0]      req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_addr,
  output logic [CNT_W-1:0] word_count,
  output logic             err
);

  // Operation indices accepted on req_op.
  localparam logic [4:0] OP_NOP     = 5'd0;
  localparam logic [4:0] OP_ADDU    = 5'd1;
  localparam logic [4:0] OP_SUBU    = 5'd2;
  localparam logic [4:0] OP_AND     = 5'd3;
  localparam logic [4:0] OP_OR      = 5'd4;
  localparam logic [4:0] OP_XOR     = 5'd5;
  localparam logic [4:0] OP_NOR     = 5'd6;
  localparam logic [4:0] OP_SLT     = 5'd7;
  localparam logic [4:0] OP_SLTU    = 5'd8;
  localparam logic [4:0] OP_SLL     = 5'd9;
  localparam logic [4:0] OP_SRL     = 5'd10;
  localparam logic [4:0] OP_SRA     = 5'd11;
  localparam logic [4:0] OP_JR      = 5'd12;
  localparam logic [4:0] OP_JALR    = 5'd13;
  localparam logic [4:0] OP_SYSCALL = 5'd14;
  localparam logic [4:0] OP_BREAK   = 5'd15;
  localparam logic [4:0] OP_ADDIU   = 5'd16;
  localparam logic [4:0] OP_ANDI    = 5'd17;
  localparam logic [4:0] OP_ORI     = 5'd18;
  localparam logic [4:0] OP_XORI    = 5'd19;
  localparam logic [4:0] OP_LUI     = 5'd20;
  localparam logic [4:0] OP_SLTI    = 5'd21;
  localparam logic [4:0] OP_LW      = 5'd22;
  localparam logic [4:0] OP_SW      = 5'd23;
  localparam logic [4:0] OP_BEQ     = 5'd24;
  localparam logic [4:0] OP_BNE     = 5'd25;
  localparam logic [4:0] OP_J       = 5'd26;
  localparam logic [4:0] OP_JAL     = 5'd27;
  localparam logic [4:0] OP_LI      = 5'd28;
  localparam logic [4:0] OP_MFC0    = 5'd29;
  localparam logic [4:0] OP_MTC0    = 5'd30;
  localparam logic [4:0] OP_ERET    = 5'd31;

  // MIPS32 primary opcodes.
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_COP0    = 6'h10;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // SPECIAL function codes.
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  // Two-state FSM: SECOND means the ORI half of an LI is still owed.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  logic [0:0]  state;
  logic [31:0] next_addr;
  logic [4:0]  hold_rt;
  logic [15:0] hold_lo;

  logic        can_load;
  logic        load_first;
  logic        load_second;

  logic [31:0] pc_plus4;
  logic [31:0] br_diff;
  logic [31:0] br_off;
  logic        br_in_range;
  logic        tgt_misaligned;
  logic        br_bad;
  logic        jmp_bad;
  logic [15:0] imm_hi;
  logic [15:0] imm_lo;

  logic [31:0] enc_inst;
  logic        enc_err;
  logic        enc_two;
  logic [31:0] second_inst;

  // The output register may take a new word when it is empty or being drained this cycle.
  assign can_load    = !out_valid || out_ready;
  assign req_ready   = !restart && (state == ST_IDLE) && can_load;
  assign load_first  = req_valid && req_ready;
  assign load_second = !restart && (state == ST_SECOND) && can_load;

  // PC-relative arithmetic is done against next_addr, the address this word will occupy.
  assign pc_plus4       = next_addr + 32'd4;
  assign br_diff        = req_imm - pc_plus4;
  assign br_off         = {{2{br_diff[31]}}, br_diff[31:2]};
  assign br_in_range    = (&br_off[31:15]) || !(|br_off[31:15]);
  assign tgt_misaligned = |req_imm[1:0];
  assign br_bad         = tgt_misaligned || !br_in_range;
  assign jmp_bad        = tgt_misaligned || (req_imm[31:28] != pc_plus4[31:28]);
  assign imm_hi         = req_imm[31:16];
  assign imm_lo         = req_imm[15:0];

  // Second half of a two-word LI: ORI rt,rt,lo from the held fields.
  assign second_inst = {OPC_ORI, hold_rt, hold_rt, hold_lo};

  // Encode the first (or only) word of the current request; unused fields stay zero.
  always_comb begin
    enc_inst = 32'h0000_0000;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    case (req_op)
      OP_NOP:     enc_inst = 32'h0000_0000;
      OP_ADDU:    enc_inst = {OPC_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_ADDU};
      OP_SUBU:    enc_inst = {OPC_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_SUBU};
      OP_AND:     enc_inst = {OPC_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_AND};
      OP_OR:      enc_inst = {OPC_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_OR};
      OP_XOR:     enc_inst = {OPC_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_XOR};
      OP_NOR:     enc_inst = {OPC_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_NOR};
      OP_SLT:     enc_inst = {OPC_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_SLT};
      OP_SLTU:    enc_inst = {OPC_SPECIAL, req_rs, req_rt, req_rd, 5'd0, FN_SLTU};
      OP_SLL:     enc_inst = {OPC_SPECIAL, 5'd0, req_rt, req_rd, req_sa, FN_SLL};
      OP_SRL:     enc_inst = {OPC_SPECIAL, 5'd0, req_rt, req_rd, req_sa, FN_SRL};
      OP_SRA:     enc_inst = {OPC_SPECIAL, 5'd0, req_rt, req_rd, req_sa, FN_SRA};
      OP_JR:      enc_inst = {OPC_SPECIAL, req_rs, 15'd0, FN_JR};
      OP_JALR:    enc_inst = {OPC_SPECIAL, req_rs, 5'd0, req_rd, 5'd0, FN_JALR};
      OP_SYSCALL: enc_inst = {OPC_SPECIAL, req_imm[19:0], FN_SYSCALL};
      OP_BREAK:   enc_inst = {OPC_SPECIAL, req_imm[19:0], FN_BREAK};
      OP_ADDIU:   enc_inst = {OPC_ADDIU, req_rs, req_rt, imm_lo};
      OP_ANDI:    enc_inst = {OPC_ANDI, req_rs, req_rt, imm_lo};
      OP_ORI:     enc_inst = {OPC_ORI, req_rs, req_rt, imm_lo};
      OP_XORI:    enc_inst = {OPC_XORI, req_rs, req_rt, imm_lo};
      OP_LUI:     enc_inst = {OPC_LUI, 5'd0, req_rt, imm_lo};
      OP_SLTI:    enc_inst = {OPC_SLTI, req_rs, req_rt, imm_lo};
      OP_LW:      enc_inst = {OPC_LW, req_rs, req_rt, imm_lo};
      OP_SW:      enc_inst = {OPC_SW, req_rs, req_rt, imm_lo};
      OP_BEQ: begin
        enc_inst = {OPC_BEQ, req_rs, req_rt, br_off[15:0]};
        enc_err  = br_bad;
      end
      OP_BNE: begin
        enc_inst = {OPC_BNE, req_rs, req_rt, br_off[15:0]};
        enc_err  = br_bad;
      end
      OP_J: begin
        enc_inst = {OPC_J, req_imm[27:2]};
        enc_err  = jmp_bad;
      end
      OP_JAL: begin
        enc_inst = {OPC_JAL, req_imm[27:2]};
        enc_err  = jmp_bad;
      end
      OP_LI: begin
        // Small values need only ORI from $0; otherwise LUI first, ORI only if lo is nonzero.
        if (imm_hi == 16'h0000) begin
          enc_inst = {OPC_ORI, 5'd0, req_rt, imm_lo};
        end else begin
          enc_inst = {OPC_LUI, 5'd0, req_rt, imm_hi};
          enc_two  = (imm_lo != 16'h0000);
        end
      end
      OP_MFC0:    enc_inst = {OPC_COP0, 5'b00000, req_rt, req_rd, 8'd0, 3'd0};
      OP_MTC0:    enc_inst = {OPC_COP0, 5'b00100, req_rt, req_rd, 8'd0, 3'd0};
      OP_ERET:    enc_inst = ERET_WORD;
      default:    enc_inst = 32'h0000_0000;
    endcase
  end

  // FSM: enter SECOND only after the LUI of a two-word LI; restart abandons the pending ORI.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (restart) begin
      state <= ST_IDLE;
    end else if (load_first) begin
      state <= enc_two ? ST_SECOND : ST_IDLE;
    end else if (load_second) begin
      state <= ST_IDLE;
    end
  end

  // Capture rt and lo of a two-word LI for the following ORI.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_rt <= 5'd0;
      hold_lo <= 16'h0000;
    end else if (load_first) begin
      hold_rt <= req_rt;
      hold_lo <= imm_lo;
    end
  end

  // Output register and address counter advance together on every word load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inst  <= 32'h0000_0000;
      out_addr  <= BASE_ADDR;
      next_addr <= BASE_ADDR;
    end else if (restart) begin
      out_valid <= 1'b0;
      next_addr <= BASE_ADDR;
    end else if (load_first) begin
      out_valid <= 1'b1;
      out_inst  <= enc_inst;
      out_addr  <= next_addr;
      next_addr <= next_addr + 32'd4;
    end else if (load_second) begin
      out_valid <= 1'b1;
      out_inst  <= second_inst;
      out_addr  <= next_addr;
      next_addr <= next_addr + 32'd4;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error: rises together with the offending word on the output register.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      err <= 1'b0;
    end else if (load_first && enc_err) begin
      err <= 1'b1;
    end
  end

  // Count words handed to the consumer; wraps naturally at CNT_W bits.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      word_count <= '0;
    end else if (out_valid && out_ready) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus randomized traffic
// scored against a field-level MIPS32 encoding model with an expected-word queue.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam int          CW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          restart = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    req_op = '0, req_rs = '0, req_rt = '0, req_rd = '0, req_sa = '0;
  logic [31:0]   req_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_inst, out_addr;
  logic [CW-1:0] word_count;
  logic          err;

  int checks = 0;
  int failures = 0;

  inst_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa),
    .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .word_count(word_count), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] inst; logic [31:0] addr; logic err; } exp_t;
  exp_t exp_q[$];
  logic [31:0] mdl_addr;

  localparam int ALU_FN [0:7] = '{33, 35, 36, 37, 38, 39, 42, 43};  // ops 1..8
  localparam int SH_FN  [0:2] = '{0, 2, 3};                         // ops 9..11
  localparam int IMM_OPC[0:7] = '{9, 12, 13, 14, 15, 10, 35, 43};   // ops 16..23

  // Returns {err, word} for every op except LI.
  function automatic logic [32:0] model_enc(input int op, input logic [31:0] rs, rt, rd, sa,
                                           input logic [31:0] imm, input logic [31:0] a);
    logic [31:0] w, ap4, diff;
    logic e;
    int off;
    w = 32'd0; e = 1'b0; ap4 = a + 32'd4;
    if (op >= 1 && op <= 8)        w = (rs << 21) | (rt << 16) | (rd << 11) | 32'(ALU_FN[op-1]);
    else if (op >= 9 && op <= 11)  w = (rt << 16) | (rd << 11) | (sa << 6) | 32'(SH_FN[op-9]);
    else if (op == 12)             w = (rs << 21) | 32'd8;
    else if (op == 13)             w = (rs << 21) | (rd << 11) | 32'd9;
    else if (op == 14 || op == 15) w = ((imm & 32'hFFFFF) << 6) | ((op == 14) ? 32'd12 : 32'd13);
    else if (op >= 16 && op <= 23)
      w = (32'(IMM_OPC[op-16]) << 26) | ((op == 20) ? 32'd0 : (rs << 21)) | (rt << 16) | (imm & 32'hFFFF);
    else if (op == 24 || op == 25) begin
      diff = imm - ap4;
      off  = $signed(diff) >>> 2;
      e    = (imm % 4 != 0) || (off > 32767) || (off < -32768);
      w    = (((op == 24) ? 32'd4 : 32'd5) << 26) | (rs << 21) | (rt << 16) | (32'(off) & 32'hFFFF);
    end else if (op == 26 || op == 27) begin
      e = (imm % 4 != 0) || ((imm >> 28) != (ap4 >> 28));
      w = (((op == 26) ? 32'd2 : 32'd3) << 26) | ((imm >> 2) & 32'h03FF_FFFF);
    end else if (op == 29)         w = (32'd16 << 26) | (rt << 16) | (rd << 11);
    else if (op == 30)             w = (32'd16 << 26) | (32'd4 << 21) | (rt << 16) | (rd << 11);
    else if (op == 31)             w = 32'h4200_0018;
    return {e, w};
  endfunction

  task automatic model_word(input logic [31:0] w, input logic e);
    exp_t x;
    x.inst = w; x.addr = mdl_addr; x.err = e;
    exp_q.push_back(x);
    mdl_addr = mdl_addr + 32'd4;
  endtask

  task automatic model_push(input int op, input logic [31:0] rs, rt, rd, sa, imm);
    logic [32:0] r;
    logic [31:0] hi, lo;
    if (op == 28) begin
      hi = imm >> 16;
      lo = imm & 32'hFFFF;
      if (hi == 0) model_word((32'd13 << 26) | (rt << 16) | lo, 1'b0);
      else begin
        model_word((32'd15 << 26) | (rt << 16) | hi, 1'b0);
        if (lo != 0) model_word((32'd13 << 26) | (rt << 21) | (rt << 16) | lo, 1'b0);
      end
    end else begin
      r = model_enc(op, rs, rt, rd, sa, imm, mdl_addr);
      model_word(r[31:0], r[32]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, rs, rt, rd, sa, input logic [31:0] imm);
    bit done;
    done = 0;
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_sa = sa; req_imm = imm;
    req_valid = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (req_ready) done = 1;
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout op=%0d req_ready never high", op);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; restart = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
    checks++; if (out_addr !== BASE) begin failures++; $display("FAIL reset_out_addr got=%h exp=%h", out_addr, BASE); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_addu();
    out_ready = 1'b0;
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addu_valid got=%b exp=1", out_valid); end
    checks++; if (out_inst !== 32'h0022_1821) begin failures++; $display("FAIL addu_inst got=%h exp=00221821", out_inst); end
    checks++; if (out_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL addu_addr got=%h exp=bfc00000", out_addr); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL addu_stall_ready got=%b exp=0", req_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (word_count !== 16'd1) begin failures++; $display("FAIL addu_count got=%0d exp=1", word_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addu_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_li();
    do_restart();
    out_ready = 1'b1;
    send(5'd28, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
    @(negedge clk);
    checks++; if (out_inst !== 32'h3C08_1234 || out_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL li_lui got=%h@%h exp=3c081234@bfc00000", out_inst, out_addr); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL li_second_ready got=%b exp=0", req_ready); end
    @(negedge clk);
    checks++; if (out_inst !== 32'h3508_5678 || out_addr !== 32'hBFC0_0004) begin failures++; $display("FAIL li_ori got=%h@%h exp=35085678@bfc00004", out_inst, out_addr); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL li_idle_ready got=%b exp=1", req_ready); end
    checks++; if (word_count !== 16'd1) begin failures++; $display("FAIL li_count got=%0d exp=1", word_count); end
    send(5'd28, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_00FF);
    @(negedge clk);
    checks++; if (out_inst !== 32'h3408_00FF || out_addr !== 32'hBFC0_0008) begin failures++; $display("FAIL li_small got=%h@%h exp=340800ff@bfc00008", out_inst, out_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || word_count !== 16'd3) begin failures++; $display("FAIL li_small_single got=v%b c%0d exp=v0 c3", out_valid, word_count); end
  endtask

  task automatic test_stall();
    do_restart();
    out_ready = 1'b0;
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    req_op = 5'd4; req_rs = 5'd5; req_rt = 5'd6; req_rd = 5'd4; req_sa = 5'd0; req_imm = 32'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_inst !== 32'h0022_1821 || out_addr !== BASE || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got=v%b %h@%h rdy=%b exp=v1 00221821@bfc00000 rdy=0", i, out_valid, out_inst, out_addr, req_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_inst !== 32'h00A6_2025 || out_addr !== 32'hBFC0_0004) begin failures++; $display("FAIL stall_next got=%h@%h exp=00a62025@bfc00004", out_inst, out_addr); end
    checks++; if (word_count !== 16'd1) begin failures++; $display("FAIL stall_count1 got=%0d exp=1", word_count); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || word_count !== 16'd2) begin failures++; $display("FAIL stall_nodup got=v%b c%0d exp=v0 c2", out_valid, word_count); end
  endtask

  task automatic test_branch();
    do_restart();
    out_ready = 1'b1;
    send(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    send(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    send(5'd24, 5'd1, 5'd2, 5'd0, 5'd0, 32'hBFC0_0000);
    @(negedge clk);
    checks++; if (out_inst !== 32'h1022_FFFD || out_addr !== 32'hBFC0_0008) begin failures++; $display("FAIL beq_word got=%h@%h exp=1022fffd@bfc00008", out_inst, out_addr); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL beq_err got=%b exp=0", err); end
    send(5'd25, 5'd1, 5'd2, 5'd0, 5'd0, 32'hBFC4_0000);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'h1422_FFFC) begin failures++; $display("FAIL bne_far_word got=v%b %h exp=v1 1422fffc", out_valid, out_inst); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL bne_far_err got=%b exp=1", err); end
    do_restart();
    @(negedge clk);
    checks++; if (err !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL restart_clears_err got=e%b v%b exp=e0 v0", err, out_valid); end
  endtask

  task automatic test_jump();
    do_restart();
    out_ready = 1'b1;
    send(5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 32'hBFC0_0100);
    @(negedge clk);
    checks++; if (out_inst !== 32'h0FF0_0040 || err !== 1'b0) begin failures++; $display("FAIL jal_word got=%h e%b exp=0ff00040 e0", out_inst, err); end
    send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (out_inst !== 32'h4200_0018) begin failures++; $display("FAIL eret_word got=%h exp=42000018", out_inst); end
    send(5'd26, 5'd0, 5'd0, 5'd0, 5'd0, 32'h8000_0000);
    @(negedge clk);
    checks++; if (out_inst !== 32'h0800_0000 || err !== 1'b1) begin failures++; $display("FAIL j_region got=%h e%b exp=08000000 e1", out_inst, err); end
  endtask

  task automatic test_restart_li();
    int late_words;
    do_restart();
    out_ready = 1'b1;
    send(5'd28, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
    @(negedge clk);
    checks++; if (out_inst !== 32'h3C08_1234) begin failures++; $display("FAIL rli_lui got=%h exp=3c081234", out_inst); end
    @(posedge clk);
    #1 out_ready = 1'b0;
    restart = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rli_restart_ready got=%b exp=0", req_ready); end
    @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || word_count !== 16'd0) begin failures++; $display("FAIL rli_after got=v%b c%0d exp=v0 c0", out_valid, word_count); end
    out_ready = 1'b1;
    late_words = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid) late_words++;
    end
    checks++; if (late_words !== 0) begin failures++; $display("FAIL rli_no_ori got=%0d exp=0", late_words); end
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (out_addr !== 32'hBFC0_0000 || out_inst !== 32'h0022_1821) begin failures++; $display("FAIL rli_next got=%h@%h exp=00221821@bfc00000", out_inst, out_addr); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL rli_count got=%0d exp=0", word_count); end
    @(negedge clk);
  endtask

  task automatic gen_req();
    int op, k, r;
    logic [31:0] tgt;
    op = $urandom_range(0, 31);
    req_op = 5'(op);
    req_rs = 5'($urandom_range(0, 31)); req_rt = 5'($urandom_range(0, 31));
    req_rd = 5'($urandom_range(0, 31)); req_sa = 5'($urandom_range(0, 31));
    req_imm = $urandom;
    r = $urandom_range(0, 9);
    if (op == 24 || op == 25) begin
      case (r)
        0: k = 32767;
        1: k = -32768;
        2: k = 32768;
        3: k = -32769;
        4: k = int'($urandom_range(0, 1 << 20)) - (1 << 19);
        default: k = int'($urandom_range(0, 200)) - 100;
      endcase
      tgt = mdl_addr + 32'd4 + 32'(k * 4);
      if (r == 5) tgt = tgt + 32'd2;
      req_imm = tgt;
    end else if (op == 26 || op == 27) begin
      tgt = ((mdl_addr + 32'd4) & 32'hF000_0000) | ($urandom & 32'h0FFF_FFFC);
      if (r == 0) tgt = tgt ^ 32'h1000_0000;
      if (r == 1) tgt = tgt | 32'd1;
      req_imm = tgt;
    end else if (op == 28) begin
      if (r < 3) req_imm = req_imm & 32'h0000_FFFF;
      else if (r < 6) req_imm = req_imm & 32'hFFFF_0000;
    end
    req_valid = 1'b1;
  endtask

  task automatic test_random();
    bit acc, hs, prev_stall;
    logic [31:0] prev_inst, prev_addr;
    logic err_exp;
    logic [CW-1:0] wc_exp;
    exp_t e;
    do_restart();
    exp_q.delete();
    mdl_addr = BASE;
    err_exp = 1'b0; wc_exp = '0; acc = 0; prev_stall = 0;
    prev_inst = '0; prev_addr = '0;
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (acc) req_valid = 1'b0;
      if (!req_valid && cyc < 1450 && $urandom_range(0, 9) < 7) gen_req();
      out_ready = (cyc >= 1450) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (word_count !== wc_exp) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, word_count, wc_exp); end
      if (prev_stall) begin
        checks++;
        if (out_inst !== prev_inst || out_addr !== prev_addr) begin
          failures++;
          $display("FAIL rnd_stable cyc=%0d got=%h@%h exp=%h@%h", cyc, out_inst, out_addr, prev_inst, prev_addr);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL rnd_stall_ready cyc=%0d got=%b exp=0", cyc, req_ready); end
      end
      hs = out_valid && out_ready;
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra_word cyc=%0d got=%h@%h exp=none", cyc, out_inst, out_addr);
        end else begin
          e = exp_q.pop_front();
          err_exp = err_exp | e.err;
          if (out_inst !== e.inst || out_addr !== e.addr || err !== err_exp) begin
            failures++;
            $display("FAIL rnd_word cyc=%0d got=%h@%h e%b exp=%h@%h e%b", cyc, out_inst, out_addr, err, e.inst, e.addr, err_exp);
          end
        end
        wc_exp = wc_exp + 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_inst = out_inst;
      prev_addr = out_addr;
      acc = req_valid && req_ready;
      if (acc) model_push(int'(req_op), 32'(req_rs), 32'(req_rt), 32'(req_rd), 32'(req_sa), req_imm);
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rnd_drain got=pending%0d v%b exp=pending0 v0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_li();
    test_stall();
    test_branch();
    test_jump();
    test_restart_li();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
